// File: rtl/aim_vector.sv
// Mouse-click to fixed-point unit aim vector: offset from shooter centre, iterative sqrt, restoring divide.
// Optional compile-time feature: AIM_DEBOUNCE_EN adds a stable-high counter on leftButton.
module aim_vector #(
    parameter int CENTER_X        = 320,
    parameter int CENTER_Y        = 240,
    parameter int SCALE           = 128,
    parameter int MIN_DIST        = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              leftButton,
    input  logic [9:0]        ClickX,
    input  logic [9:0]        ClickY,
    input  logic              shot_active,
    output logic signed [8:0] x_vector,
    output logic signed [8:0] y_vector,
    output logic              vec_valid,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, SQUARE, SQRT, DIV, DONE} state_t;

    localparam int                SCALE_SH = $clog2(SCALE);
    localparam logic signed [10:0] CX      = 11'(CENTER_X);
    localparam logic signed [10:0] CY      = 11'(CENTER_Y);
    localparam logic [19:0]        MIN_SQ  = 20'(MIN_DIST * MIN_DIST);

    state_t             state;
    logic signed [10:0] dx, dy;
    logic [17:0]        sq_rad;
    logic [9:0]         sq_rem;
    logic [8:0]         sq_root;
    logic [3:0]         iter;
    logic [17:0]        num_x, num_y, den;
    logic [7:0]         q_x, q_y;
    logic               press;

    function automatic logic [9:0] mag_of(input logic signed [10:0] v);
        return v[10] ? 10'(-v) : 10'(v);
    endfunction

    // Sign is applied after the magnitude divide, so results round toward zero.
    function automatic logic signed [8:0] apply_sign(input logic [7:0] q, input logic neg);
        logic signed [8:0] m;
        m = signed'({1'b0, q});
        return neg ? -m : m;
    endfunction

`ifdef AIM_DEBOUNCE_EN
    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    logic [CNT_W-1:0] db_cnt;

    // Counter saturates so a held button fires only once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)              db_cnt <= '0;
        else if (!leftButton)      db_cnt <= '0;
        else if (db_cnt != CNT_MAX) db_cnt <= db_cnt + 1'b1;
    end

    assign press = leftButton && (db_cnt == CNT_MAX - 1'b1);
`else
    logic btn_prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) btn_prev <= 1'b0;
        else          btn_prev <= leftButton;
    end

    assign press = leftButton && !btn_prev;
`endif

    logic signed [10:0] dx_c, dy_c;
    logic [9:0]         ax, ay;
    logic [19:0]        mag2_c;
    logic [11:0]        rem_sh, trial;
    logic [9:0]         rem_next;
    logic [8:0]         root_next;

    assign dx_c   = signed'({1'b0, ClickX}) - CX;
    assign dy_c   = CY - signed'({1'b0, ClickY});
    assign ax     = mag_of(dx);
    assign ay     = mag_of(dy);
    assign mag2_c = 20'(ax) * 20'(ax) + 20'(ay) * 20'(ay);

    // One bit-pair of the square root per cycle.
    always_comb begin
        rem_sh = {sq_rem, sq_rad[17:16]};
        trial  = {1'b0, sq_root, 2'b01};
        if (rem_sh >= trial) begin
            rem_next  = 10'(rem_sh - trial);
            root_next = {sq_root[7:0], 1'b1};
        end else begin
            rem_next  = rem_sh[9:0];
            root_next = {sq_root[7:0], 1'b0};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            dx        <= '0;
            dy        <= '0;
            sq_rad    <= '0;
            sq_rem    <= '0;
            sq_root   <= '0;
            iter      <= '0;
            num_x     <= '0;
            num_y     <= '0;
            den       <= '0;
            q_x       <= '0;
            q_y       <= '0;
            x_vector  <= '0;
            y_vector  <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            vec_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (press && !shot_active) begin
                        dx    <= dx_c;
                        dy    <= dy_c;
                        busy  <= 1'b1;
                        state <= SQUARE;
                    end
                end
                SQUARE: begin
                    sq_rad  <= 18'(mag2_c);
                    sq_rem  <= '0;
                    sq_root <= '0;
                    iter    <= '0;
                    num_x   <= 18'(ax) << SCALE_SH;
                    num_y   <= 18'(ay) << SCALE_SH;
                    q_x     <= '0;
                    q_y     <= '0;
                    if (mag2_c < MIN_SQ) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= SQRT;
                    end
                end
                SQRT: begin
                    sq_rad  <= sq_rad << 2;
                    sq_rem  <= rem_next;
                    sq_root <= root_next;
                    if (iter == 4'd8) begin
                        // Divisor starts at mag<<7 to produce quotient bit 7 first.
                        den   <= 18'(root_next) << 7;
                        iter  <= '0;
                        state <= DIV;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                DIV: begin
                    num_x <= (num_x >= den) ? num_x - den : num_x;
                    num_y <= (num_y >= den) ? num_y - den : num_y;
                    q_x   <= {q_x[6:0], num_x >= den};
                    q_y   <= {q_y[6:0], num_y >= den};
                    den   <= den >> 1;
                    if (iter == 4'd7) state <= DONE;
                    else              iter  <= iter + 1'b1;
                end
                DONE: begin
                    x_vector  <= apply_sign(q_x, dx[10]);
                    y_vector  <= apply_sign(q_y, dy[10]);
                    vec_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aim_vector.md
# aim_vector

Converts a mouse click into the fixed-point unit direction vector consumed by the shooter-ball motion stage. On a qualified left-button press it captures the click position and forms the offset from the shooter centre with Y pointing up. It then computes the integer magnitude with an iterative square root and divides each component by it with an iterative restoring divider. It presents signed 9-bit components scaled to `SCALE` together with a one-cycle valid pulse, between the mouse interface and the shot-ball motion logic.

## Interface
- `CENTER_X`, 320: shooter centre X, pixels.
- `CENTER_Y`, 240: shooter centre Y, pixels.
- `SCALE`, 128: output length of a unit vector; must be a power of two, ≤128.
- `MIN_DIST`, 8: clicks with distance² < `MIN_DIST`² are rejected; must be ≥1.
- `DEBOUNCE_CYCLES`, 4: stable-high cycles required when debounce is compiled in.

- `Clk` in 1: system clock, 50 MHz.
- `Reset_n` in 1: reset, asynchronous, active-low.
- `leftButton` in 1: raw left mouse button level.
- `ClickX` in 10: cursor X, 0–639.
- `ClickY` in 10: cursor Y, 0–479.
- `shot_active` in 1: high while a ball is in flight; new presses are ignored.
- `x_vector` out 9: signed two's-complement X component, +right.
- `y_vector` out 9: signed two's-complement Y component, +up.
- `vec_valid` out 1: one-cycle pulse when a new vector is presented.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Press detect: a registered copy of `leftButton` is kept at all times. A press is a sample of 1 when the previous sample was 0.
- Capture: a press is accepted only in IDLE with `shot_active`=0. Presses seen in any other state, or while `shot_active`=1, are dropped and never queued.
- `ClickX`/`ClickY` are sampled only at the capture edge.
- Offsets are 11-bit signed: dx = ClickX − CENTER_X, dy = CENTER_Y − ClickY.
- FSM states and transitions:
  - IDLE: waits for an accepted press. Capture latches dx and dy and moves to SQUARE.
  - SQUARE: forms mag² = dx²+dy², 18 bits unsigned (maximum 160000). If mag² < MIN_DIST², goes to IDLE with no `vec_valid`; otherwise goes to SQRT.
  - SQRT: 9 iterations of bit-by-bit integer square root, giving mag = floor(√mag²) in 9 bits. Then goes to DIV.
  - DIV: 8 iterations of restoring division, X and Y in parallel. Each computes q = floor(|d|·SCALE / mag), 8 bits, with q ≤ SCALE. Then goes to DONE.
  - DONE: outputs the components, applying the sign after the magnitude divide (rounding toward zero). Asserts `vec_valid`, then goes to IDLE.
- `x_vector`/`y_vector` hold their last value until the next DONE.
- Reset: every register clears asynchronously and the FSM goes to IDLE. Reset mid-computation abandons the computation; no `vec_valid` is produced for it.

## Timing
- Reset values: `x_vector`=0, `y_vector`=0, `vec_valid`=0, `busy`=0, FSM=IDLE, button history=0.
- Capture edge = edge 0. SQUARE is evaluated at edge 1, SQRT runs on edges 2–10, DIV on edges 11–18, and DONE on edge 19.
- `vec_valid` and the new outputs appear after edge 19; `vec_valid` drops after edge 20.
- `busy` is high from after edge 0 until after edge 19, i.e. until the FSM is back in IDLE. A rejected click has `busy` high for 1 cycle.
- The earliest next capture is at edge 20.
- If the button is held through DONE, no new press is seen until it is released and pressed again.

## Configuration
- `AIM_DEBOUNCE_EN` defined: a counter requires `leftButton` to be sampled high on `DEBOUNCE_CYCLES` consecutive edges after a low sample.
  - The capture edge is the edge at which the count is reached; the counter clears on any low sample.
  - All other timing is relative to that capture edge.
- `AIM_DEBOUNCE_EN` undefined: the single-sample rising edge is used, and the counter is absent.

## Test plan
- Click (420,240) → dx=100, dy=0, mag=100 → `x_vector`=128 (0x080), `y_vector`=0. `vec_valid` is a single pulse 19 edges after capture.
- Click (380,160) → dx=60, dy=80, mag=100 → `x_vector`=76 (0x04C), `y_vector`=102 (0x066).
- Click (260,320) → dx=−60, dy=−80, mag=100 → `x_vector`=−76 (0x1B4), `y_vector`=−102 (0x19A).
- Click (323,242): mag²=13 < 64 → no `vec_valid`, `busy` high for 1 cycle, outputs keep their prior values.
- Each of these cases produces no capture and no `vec_valid`:
  - a press with `shot_active`=1;
  - a second press during SQRT;
  - `Reset_n` pulled low at edge 12 of a valid computation; in this case outputs also go to 0 immediately.
- With `AIM_DEBOUNCE_EN` and a 2-cycle high glitch: no capture. A 4-cycle high pulse captures at its 4th edge.
